// File: rtl/int_arr_gather.sv
// Gathers a scalar i32 stream into groups of four 13-bit signed elements.
// Elements are truncated or saturated. A flush request emits a partial group padded with zeros.
module int_arr_gather #(
    parameter bit SATURATE = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] ints_data,
    input  logic        ints_valid,
    output logic        ints_ready,
    output logic [12:0] arr_data0,
    output logic [12:0] arr_data1,
    output logic [12:0] arr_data2,
    output logic [12:0] arr_data3,
    output logic        arr_valid,
    input  logic        arr_ready,
    input  logic        flush,
    output logic [15:0] satCount
);

    localparam int DATA_W = 32;
    localparam int ELEM_W = 13;

    function automatic logic signed [ELEM_W-1:0] conv(input logic signed [DATA_W-1:0] x);
        if (SATURATE && x > 32'sd4095)  return 13'sh0FFF;
        if (SATURATE && x < -32'sd4096) return 13'sh1000;
        return $signed(x[ELEM_W-1:0]);
    endfunction

    function automatic logic clamped(input logic signed [DATA_W-1:0] x);
        return SATURATE && (x > 32'sd4095 || x < -32'sd4096);
    endfunction

    logic signed [ELEM_W-1:0] slot_p0 [4];
    logic [1:0]               idx_p0;
    logic                     flush_pend;
    logic signed [ELEM_W-1:0] out_p1 [4];
    logic                     vld_p1;

    logic signed [ELEM_W-1:0] cur_p0;
    logic signed [ELEM_W-1:0] grp_p0 [4];
    logic                     clamp_p0;
    logic                     acc, out_free, flush_req, load;
    logic [2:0]               cnt;

    assign ints_ready = rstn && !flush_pend && (idx_p0 != 2'd3 || !vld_p1 || arr_ready);

    always_comb begin
        cur_p0    = conv(ints_data);
        clamp_p0  = clamped(ints_data);
        acc       = ints_valid && ints_ready;
        out_free  = !vld_p1 || arr_ready;
        flush_req = flush || flush_pend;
        // cnt is the number of filled slots once this cycle's accept is stored
        cnt       = {1'b0, idx_p0} + {2'b00, acc};
        load      = out_free && (cnt == 3'd4 || (flush_req && cnt != 3'd0));
        for (int k = 0; k < 4; k++) begin
            grp_p0[k] = slot_p0[k];
            if (acc && idx_p0 == 2'(k)) grp_p0[k] = cur_p0;
            if (3'(k) >= cnt)           grp_p0[k] = '0;
        end
    end

    // Stage p0: slot capture and group control
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx_p0     <= 2'd0;
            flush_pend <= 1'b0;
            satCount   <= 16'd0;
            for (int k = 0; k < 4; k++) slot_p0[k] <= '0;
        end else begin
            if (acc) slot_p0[idx_p0] <= cur_p0;
            idx_p0     <= load ? 2'd0 : cnt[1:0];
            flush_pend <= flush_req && cnt != 3'd0 && !load;
            if (acc && clamp_p0 && satCount != 16'hFFFF) satCount <= satCount + 16'd1;
        end
    end

    // Stage p1: output register, held while stalled
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            for (int k = 0; k < 4; k++) out_p1[k] <= '0;
        end else if (load) begin
            vld_p1 <= 1'b1;
            for (int k = 0; k < 4; k++) out_p1[k] <= grp_p0[k];
        end else if (arr_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign arr_valid = vld_p1;
    assign arr_data0 = out_p1[0];
    assign arr_data1 = out_p1[1];
    assign arr_data2 = out_p1[2];
    assign arr_data3 = out_p1[3];

endmodule

// File: tb/tb_int_arr_gather.sv
// Bench for int_arr_gather: truncating and saturating instances share one stimulus stream.
// A scoreboard predicts each emitted group.
module tb_int_arr_gather;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, ints_valid, flush, arr_ready;
    logic [31:0] ints_data;
    logic        ints_ready0, ints_ready1, arr_valid0, arr_valid1;
    logic [12:0] a0_0, a0_1, a0_2, a0_3, a1_0, a1_1, a1_2, a1_3;
    logic [15:0] satc0, satc1;

    int_arr_gather #(.SATURATE(1'b0)) u_trunc (
        .clk(clk), .rstn(rstn), .ints_data(ints_data), .ints_valid(ints_valid),
        .ints_ready(ints_ready0), .arr_data0(a0_0), .arr_data1(a0_1), .arr_data2(a0_2),
        .arr_data3(a0_3), .arr_valid(arr_valid0), .arr_ready(arr_ready), .flush(flush),
        .satCount(satc0));

    int_arr_gather #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .rstn(rstn), .ints_data(ints_data), .ints_valid(ints_valid),
        .ints_ready(ints_ready1), .arr_data0(a1_0), .arr_data1(a1_1), .arr_data2(a1_2),
        .arr_data3(a1_3), .arr_valid(arr_valid1), .arr_ready(arr_ready), .flush(flush),
        .satCount(satc1));

    typedef struct {
        logic [31:0] din;
        logic [12:0] et;
        logic [12:0] es;
        bit          clamp;
    } vec_t;

    vec_t        vt [16];
    logic [51:0] q_exp0 [$];
    logic [51:0] q_exp1 [$];
    logic [12:0] part0 [4];
    logic [12:0] part1 [4];
    int          npart = 0;
    int          nvec = 0, nfail = 0, ndrain = 0;
    bit          last_acc;

    logic [31:0] v_data;
    logic [12:0] v_et, v_es;
    bit          v_clamp;
    logic        v_valid, v_flush, v_ready, v_rstn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_part();
        npart = 0;
        for (int k = 0; k < 4; k++) begin
            part0[k] = '0;
            part1[k] = '0;
        end
    endtask

    task automatic push_part();
        q_exp0.push_back({part0[3], part0[2], part0[1], part0[0]});
        q_exp1.push_back({part1[3], part1[2], part1[1], part1[0]});
        clear_part();
    endtask

    // One cycle: drive at the falling edge, then observe the settled handshakes.
    task automatic tick();
        @(negedge clk);
        rstn = v_rstn; ints_data = v_data; ints_valid = v_valid;
        flush = v_flush; arr_ready = v_ready;
        #1;
        last_acc = 1'b0;
        if (!rstn) begin
            chk("ready_in_reset", ints_ready0, 1'b0);
            clear_part();
            q_exp0.delete();
            q_exp1.delete();
            return;
        end
        chk("ready_agree", ints_ready1, ints_ready0);
        if (arr_valid0 && arr_ready) begin
            ndrain++;
            if (q_exp0.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL unexpected_group: got %0h, expected no group",
                         {a0_3, a0_2, a0_1, a0_0});
            end else begin
                chk("group_trunc", {a0_3, a0_2, a0_1, a0_0}, q_exp0.pop_front());
                chk("group_sat", {a1_3, a1_2, a1_1, a1_0}, q_exp1.pop_front());
            end
        end
        if (ints_valid && ints_ready0) begin
            last_acc = 1'b1;
            part0[npart] = v_et;
            part1[npart] = v_es;
            npart++;
            if (npart == 4) push_part();
        end
        if (flush && npart != 0) push_part();
    endtask

    task automatic send(input logic [31:0] d, input logic [12:0] et, input logic [12:0] es,
                        input bit cl);
        v_data = d; v_et = et; v_es = es; v_clamp = cl; v_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) begin
            nvec++; nfail++;
            $display("FAIL send_timeout: got no accept, expected accept of %0h", d);
        end
        v_valid = 1'b0;
    endtask

    task automatic sendp(input logic [31:0] d);
        send(d, d[12:0], d[12:0], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    int drops, n0, k;

    initial begin
        vt = '{
            '{32'd5000,      13'h1388, 13'h0FFF, 1'b1},
            '{32'hFFFFEC78,  13'h0C78, 13'h1000, 1'b1},
            '{32'd4095,      13'h0FFF, 13'h0FFF, 1'b0},
            '{32'hFFFFF000,  13'h1000, 13'h1000, 1'b0},
            '{32'd4096,      13'h1000, 13'h0FFF, 1'b1},
            '{32'hFFFFEFFF,  13'h0FFF, 13'h1000, 1'b1},
            '{32'h7FFFFFFF,  13'h1FFF, 13'h0FFF, 1'b1},
            '{32'h80000000,  13'h0000, 13'h1000, 1'b1},
            '{32'hFFFFFFFF,  13'h1FFF, 13'h1FFF, 1'b0},
            '{32'd0,         13'h0000, 13'h0000, 1'b0},
            '{32'd100,       13'h0064, 13'h0064, 1'b0},
            '{32'hFFFFFF9C,  13'h1F9C, 13'h1F9C, 1'b0},
            '{32'd1,         13'h0001, 13'h0001, 1'b0},
            '{32'd2,         13'h0002, 13'h0002, 1'b0},
            '{32'd3,         13'h0003, 13'h0003, 1'b0},
            '{32'd4,         13'h0004, 13'h0004, 1'b0}
        };
        clear_part();
        v_rstn = 1'b0; v_valid = 1'b1; v_flush = 1'b0; v_ready = 1'b1; v_data = 32'd0;
        v_et = '0; v_es = '0; v_clamp = 1'b0;
        tick(); tick();
        v_rstn = 1'b1; v_valid = 1'b0;
        tick();
        chk("reset_valid", arr_valid0, 1'b0);
        chk("reset_data", {a0_3, a0_2, a0_1, a0_0}, 52'd0);
        chk("reset_satcount", satc1, 16'd0);
        chk("idle_ready", ints_ready0, 1'b1);

        // Basic group, one-cycle latency, then valid drops after the drain
        sendp(1); sendp(2); sendp(3); sendp(4);
        tick();
        chk("latency_valid", arr_valid0, 1'b1);
        chk("basic_group", {a0_3, a0_2, a0_1, a0_0}, {13'd4, 13'd3, 13'd2, 13'd1});
        tick();
        chk("valid_drop", arr_valid0, 1'b0);

        // Backpressure: first group held, 8 blocked until the drain
        v_ready = 1'b0;
        for (int i = 1; i <= 7; i++) sendp(i);
        v_data = 32'd8; v_et = 13'd8; v_es = 13'd8; v_clamp = 1'b0; v_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_ready_low", ints_ready0, 1'b0);
            chk("bp_stable", {a0_3, a0_2, a0_1, a0_0}, {13'd4, 13'd3, 13'd2, 13'd1});
        end
        v_ready = 1'b1;
        tick();
        chk("bp_accept_on_drain", last_acc, 1'b1);
        v_valid = 1'b0;
        tick();
        chk("bp_no_bubble", arr_valid0, 1'b1);
        chk("bp_second_group", {a0_3, a0_2, a0_1, a0_0}, {13'd8, 13'd7, 13'd6, 13'd5});
        tick();

        // Conversion table
        for (int i = 0; i < 16; i++) begin
            send(vt[i].din, vt[i].et, vt[i].es, vt[i].clamp);
            if (i == 3) begin
                tick();
                chk("satcount_first4", satc1, 16'd2);
            end
        end
        tick(); tick();
        chk("satcount_table", satc1, 16'd6);
        chk("satcount_trunc", satc0, 16'd0);

        // Partial flush, then flush with nothing gathered
        sendp(7); sendp(9);
        v_flush = 1'b1; tick(); v_flush = 1'b0;
        tick();
        chk("flush_valid", arr_valid0, 1'b1);
        chk("flush_group", {a0_3, a0_2, a0_1, a0_0}, {13'd0, 13'd0, 13'd9, 13'd7});
        tick();
        v_flush = 1'b1; tick(); tick(); v_flush = 1'b0;
        chk("empty_flush", arr_valid0, 1'b0);
        tick();
        chk("empty_flush_after", arr_valid0, 1'b0);

        // Flush while the output is stalled goes pending and blocks input
        v_ready = 1'b0;
        sendp(1); sendp(2); sendp(3); sendp(4); sendp(5);
        v_flush = 1'b1; tick(); v_flush = 1'b0;
        v_data = 32'd6; v_et = 13'd6; v_es = 13'd6; v_valid = 1'b1;
        tick();
        chk("pend_ready_low", ints_ready0, 1'b0);
        v_valid = 1'b0; v_ready = 1'b1;
        tick(); tick();
        chk("pend_valid", arr_valid0, 1'b1);
        chk("pend_group", {a0_3, a0_2, a0_1, a0_0}, {13'd0, 13'd0, 13'd0, 13'd5});
        tick();

        // Flush coinciding with accepts
        sendp(1); sendp(2); sendp(3);
        v_flush = 1'b1; sendp(4); v_flush = 1'b0;
        tick();
        chk("flush_full_group", {a0_3, a0_2, a0_1, a0_0}, {13'd4, 13'd3, 13'd2, 13'd1});
        tick();
        chk("flush_consumed", arr_valid0, 1'b0);
        sendp(1);
        v_flush = 1'b1; sendp(2); v_flush = 1'b0;
        tick();
        chk("flush_with_accept", {a0_3, a0_2, a0_1, a0_0}, {13'd0, 13'd0, 13'd2, 13'd1});
        tick();

        // Reset mid-group and reset with a pending output
        sendp(11); sendp(12);
        v_rstn = 1'b0; tick(); v_rstn = 1'b1;
        sendp(1); sendp(2); sendp(3); sendp(4);
        tick();
        chk("post_reset_group", {a0_3, a0_2, a0_1, a0_0}, {13'd4, 13'd3, 13'd2, 13'd1});
        chk("post_reset_satcount", satc1, 16'd0);
        tick();
        v_ready = 1'b0;
        sendp(1); sendp(2); sendp(3); sendp(4);
        v_rstn = 1'b0; tick(); v_rstn = 1'b1;
        tick();
        chk("reset_drops_output", arr_valid0, 1'b0);
        v_ready = 1'b1;
        tick();
        chk("reset_drops_output2", arr_valid0, 1'b0);

        // Continuous streaming
        drops = 0; n0 = ndrain; k = 1; v_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v_data = k; v_et = 13'(k); v_es = 13'(k); v_clamp = 1'b0;
            tick();
            if (!ints_ready0) drops++;
            if (last_acc) k++;
        end
        v_valid = 1'b0;
        tick(); tick();
        chk("stream_ready_drops", drops, 0);
        chk("stream_accepts", k, 41);
        chk("stream_groups", ndrain - n0, 10);

        chk("scoreboard_empty", q_exp0.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
